// File: rtl/car_control_sequencer.sv
// Transfer-stage control for the counter address registers (PCRA0, PCRA1, SP, SI, DI):
// registered micro-op strobes plus an autonomous SI-to-DI block-move sequencer.
module car_control_sequencer #(
  parameter int CNT_W = 16,
  parameter int NREG  = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_addr_sel,
  input  logic [2:0]       op_xassert_sel,
  input  logic [2:0]       op_xload_sel,
  input  logic [NREG-1:0]  op_inc,
  input  logic [NREG-1:0]  op_dec,
  input  logic             blk_start,
  input  logic             blk_dir,
  input  logic [CNT_W-1:0] blk_count,
  output logic             blk_busy,
  output logic             blk_done,
  output logic [NREG-1:0]  car_inc,
  output logic [NREG-1:0]  car_dec,
  output logic [NREG-1:0]  car_xload_n,
  output logic [NREG-1:0]  car_xassert_n,
  output logic [NREG-1:0]  car_addr_n,
  output logic             mem_rd,
  output logic             mem_wr
);

  localparam int SI = 3;
  localparam int DI = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic             dir, dir_next;
  logic             op_fire;

  logic [NREG-1:0]  inc_next, dec_next, xload_n_next, xassert_n_next, addr_n_next;
  logic             mem_rd_next, mem_wr_next, done_next;

  // A pending block move takes priority over a micro-op presented in the same cycle.
  assign op_ready = (state == IDLE) & ~blk_start;
  assign op_fire  = op_valid & op_ready;
  assign blk_busy = (state != IDLE);

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    dir_next       = dir;
    case (state)
      IDLE: begin
        if (blk_start) begin
          dir_next       = blk_dir;
          remaining_next = blk_count;
          state_next     = (blk_count == '0) ? DONE : RD;
        end
      end
      RD: state_next = WR;
      WR: begin
        if (remaining != '0) remaining_next = remaining - 1'b1;
        state_next = (remaining <= CNT_W'(1)) ? DONE : RD;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are computed for the cycle after the edge, from the accepted op or the state being entered.
  always_comb begin
    inc_next       = '0;
    dec_next       = '0;
    xload_n_next   = '1;
    xassert_n_next = '1;
    addr_n_next    = '1;
    mem_rd_next    = 1'b0;
    mem_wr_next    = 1'b0;
    done_next      = 1'b0;
    if (op_fire) begin
      for (int i = 0; i < NREG; i++) begin
        addr_n_next[i]    = (op_addr_sel != 3'(i));
        xassert_n_next[i] = (op_xassert_sel != 3'(i));
        xload_n_next[i]   = (op_xload_sel != 3'(i));
        inc_next[i]       = op_inc[i] & ~op_dec[i] & (op_xload_sel != 3'(i));
        dec_next[i]       = op_dec[i] & ~op_inc[i] & (op_xload_sel != 3'(i));
      end
    end
    case (state_next)
      RD: begin
        addr_n_next[SI] = 1'b0;
        mem_rd_next     = 1'b1;
        if (dir_next) dec_next[SI] = 1'b1;
        else          inc_next[SI] = 1'b1;
      end
      WR: begin
        addr_n_next[DI] = 1'b0;
        mem_wr_next     = 1'b1;
        if (dir_next) dec_next[DI] = 1'b1;
        else          inc_next[DI] = 1'b1;
      end
      DONE:    done_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state         <= IDLE;
      remaining     <= '0;
      dir           <= 1'b0;
      car_inc       <= '0;
      car_dec       <= '0;
      car_xload_n   <= '1;
      car_xassert_n <= '1;
      car_addr_n    <= '1;
      mem_rd        <= 1'b0;
      mem_wr        <= 1'b0;
      blk_done      <= 1'b0;
    end else begin
      state         <= state_next;
      remaining     <= remaining_next;
      dir           <= dir_next;
      car_inc       <= inc_next;
      car_dec       <= dec_next;
      car_xload_n   <= xload_n_next;
      car_xassert_n <= xassert_n_next;
      car_addr_n    <= addr_n_next;
      mem_rd        <= mem_rd_next;
      mem_wr        <= mem_wr_next;
      blk_done      <= done_next;
    end
  end

endmodule
